bf_uart_prog_loader: RTL and testbench

- Sits between the UART receive AXI-stream and the brainfuck core/program memory.
- After reset or a reload request, it consumes UART bytes as program source. It filters out non-command characters, encodes each command to a 3-bit opcode and writes it into program RAM. It holds the core in reset until the terminator '!' (0x21) arrives.
- Once loading is done, it passes the UART receive stream through to the core for ',' input.

---
 rtl/bf_uart_prog_loader.sv | 151 +++++++++++++++
 tb/tb_bf_uart_prog_loader.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_uart_prog_loader.sv
// Brainfuck program loader: filters UART bytes into 3-bit opcodes written to program RAM,
// then releases the core and passes the receive stream through once '!' arrives.
module bf_uart_prog_loader #(
    parameter int unsigned PROG_ADDR_WIDTH = 11,
    parameter int unsigned PROG_DATA_WIDTH = 3,
    parameter int unsigned NEST_WIDTH      = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       reload,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_ready,
    output logic                       rx_clear,
    output logic [7:0]                 core_rx_data,
    output logic                       core_rx_ready,
    input  logic                       core_rx_clear,
    output logic [PROG_ADDR_WIDTH-1:0] prog_wr_addr,
    output logic [PROG_DATA_WIDTH-1:0] prog_wr_data,
    output logic                       prog_wr_en,
    output logic [PROG_ADDR_WIDTH:0]   prog_len,
    output logic                       core_rst,
    output logic                       load_done,
    output logic                       err_overflow,
    output logic                       err_unbalanced
);

    localparam logic [PROG_ADDR_WIDTH:0] Capacity = {1'b1, {PROG_ADDR_WIDTH{1'b0}}};
    localparam logic [7:0] CharTerm = 8'h21;
    localparam logic [7:0] CharOpen = 8'h5B;
    localparam logic [7:0] CharClose = 8'h5D;

    typedef enum logic [1:0] {StLoad, StDone, StError} state_e;

    state_e                       state_q, state_d;
    logic                         wr_en_q, wr_en_d;
    logic [PROG_ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [PROG_DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic [PROG_ADDR_WIDTH:0]     count_q, count_d;
    logic [NEST_WIDTH-1:0]        nest_q, nest_d;
    logic                         ovf_q, ovf_d;
    logic                         unb_q, unb_d;
    logic                         done_q, done_d;
    logic                         core_rst_q, core_rst_d;
    logic                         is_cmd;
    logic [2:0]                   opcode;

    always_comb begin
        is_cmd = 1'b1;
        opcode = 3'd0;
        case (rx_data)
            8'h3E:   opcode = 3'd0;
            8'h3C:   opcode = 3'd1;
            8'h2B:   opcode = 3'd2;
            8'h2D:   opcode = 3'd3;
            8'h2E:   opcode = 3'd4;
            8'h2C:   opcode = 3'd5;
            8'h5B:   opcode = 3'd6;
            8'h5D:   opcode = 3'd7;
            default: is_cmd = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        count_d       = count_q;
        nest_d        = nest_q;
        ovf_d         = ovf_q;
        unb_d         = unb_q;
        rx_clear      = 1'b0;
        core_rx_ready = 1'b0;
        core_rx_data  = 8'h00;
        case (state_q)
            StLoad: begin
                rx_clear = rx_ready;
                if (rx_ready) begin
                    if (is_cmd) begin
                        if (count_q == Capacity) begin
                            ovf_d = 1'b1;
                        end else begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = count_q[PROG_ADDR_WIDTH-1:0];
                            wr_data_d = PROG_DATA_WIDTH'(opcode);
                            count_d   = count_q + 1'b1;
                        end
                        // Depth saturates; overflowing the counter counts as a mismatch.
                        if (rx_data == CharOpen) begin
                            if (&nest_q) unb_d = 1'b1;
                            else         nest_d = nest_q + 1'b1;
                        end else if (rx_data == CharClose) begin
                            if (nest_q == '0) unb_d = 1'b1;
                            else              nest_d = nest_q - 1'b1;
                        end
                    end else if (rx_data == CharTerm) begin
                        if (nest_q != '0) unb_d = 1'b1;
                        state_d = (ovf_q || unb_d) ? StError : StDone;
                    end
                end
            end
            StDone: begin
                core_rx_data  = rx_data;
                core_rx_ready = rx_ready;
                rx_clear      = core_rx_clear;
            end
            StError: begin
                rx_clear = rx_ready;
            end
            default: state_d = StLoad;
        endcase
        done_d     = (state_d == StDone);
        core_rst_d = (state_d != StDone);
    end

    always_ff @(posedge clk) begin
        if (rst || reload) begin
            state_q    <= StLoad;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            count_q    <= '0;
            nest_q     <= '0;
            ovf_q      <= 1'b0;
            unb_q      <= 1'b0;
            done_q     <= 1'b0;
            core_rst_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            count_q    <= count_d;
            nest_q     <= nest_d;
            ovf_q      <= ovf_d;
            unb_q      <= unb_d;
            done_q     <= done_d;
            core_rst_q <= core_rst_d;
        end
    end

    assign prog_wr_en     = wr_en_q;
    assign prog_wr_addr   = wr_addr_q;
    assign prog_wr_data   = wr_data_q;
    assign prog_len       = count_q;
    assign err_overflow   = ovf_q;
    assign err_unbalanced = unb_q;
    assign load_done      = done_q;
    assign core_rst       = core_rst_q | rst;

endmodule

// File: tb/tb_bf_uart_prog_loader.sv
// Bench for bf_uart_prog_loader: table vectors, hand sequences and random programs checked
// against a string-level model of the loading rules.
module tb_bf_uart_prog_loader;

    localparam int AW       = 2;
    localparam int NW       = 2;
    localparam int CAP      = 1 << AW;
    localparam int NEST_MAX = (1 << NW) - 1;

    logic          clk = 1'b0;
    logic          rst, reload, rx_ready, core_rx_clear;
    logic [7:0]    rx_data;
    logic          rx_clear, core_rx_ready, prog_wr_en, core_rst;
    logic          load_done, err_overflow, err_unbalanced;
    logic [7:0]    core_rx_data;
    logic [AW-1:0] prog_wr_addr;
    logic [2:0]    prog_wr_data;
    logic [AW:0]   prog_len;

    bf_uart_prog_loader #(
        .PROG_ADDR_WIDTH(AW),
        .PROG_DATA_WIDTH(3),
        .NEST_WIDTH     (NW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .reload        (reload),
        .rx_data       (rx_data),
        .rx_ready      (rx_ready),
        .rx_clear      (rx_clear),
        .core_rx_data  (core_rx_data),
        .core_rx_ready (core_rx_ready),
        .core_rx_clear (core_rx_clear),
        .prog_wr_addr  (prog_wr_addr),
        .prog_wr_data  (prog_wr_data),
        .prog_wr_en    (prog_wr_en),
        .prog_len      (prog_len),
        .core_rst      (core_rst),
        .load_done     (load_done),
        .err_overflow  (err_overflow),
        .err_unbalanced(err_unbalanced)
    );

    always #5 clk = ~clk;

    typedef struct {
        string prog;
        int    len;
        bit    done;
        bit    ovf;
        bit    unb;
    } vec_t;

    int           checks = 0;
    int           errors = 0;
    byte unsigned cur_q[$];
    int           obs_q[$];
    int           exp_q[$];
    int           m_len;
    bit           m_done, m_ovf, m_unb;

    // Every write strobe seen, encoded as addr*8+opcode.
    always @(negedge clk) begin
        if (prog_wr_en === 1'b1) obs_q.push_back(int'(prog_wr_addr) * 8 + int'(prog_wr_data));
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int opcode_of(input byte unsigned c);
        byte unsigned cmds[8] = '{8'h3E, 8'h3C, 8'h2B, 8'h2D, 8'h2E, 8'h2C, 8'h5B, 8'h5D};
        for (int k = 0; k < 8; k++) if (cmds[k] == c) return k;
        return -1;
    endfunction

    task automatic model_run();
        int           depth = 0;
        int           cnt = 0;
        int           op;
        byte unsigned c;
        m_ovf = 0; m_unb = 0; m_done = 0;
        exp_q.delete();
        foreach (cur_q[i]) begin
            c  = cur_q[i];
            op = opcode_of(c);
            if (c == 8'h21) begin
                if (depth != 0) m_unb = 1;
                m_done = !(m_ovf || m_unb);
                break;
            end
            if (op >= 0) begin
                if (cnt < CAP) begin
                    exp_q.push_back(cnt * 8 + op);
                    cnt++;
                end else begin
                    m_ovf = 1;
                end
                if (c == 8'h5B) begin
                    if (depth == NEST_MAX) m_unb = 1;
                    else depth++;
                end else if (c == 8'h5D) begin
                    if (depth == 0) m_unb = 1;
                    else depth--;
                end
            end
        end
        m_len = cnt;
    endtask

    task automatic load_str(input string s);
        cur_q.delete();
        for (int i = 0; i < s.len(); i++) cur_q.push_back(s[i]);
    endtask

    task automatic do_reset();
        rst = 1'b1; reload = 1'b0; rx_ready = 1'b0; core_rx_clear = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        obs_q.delete();
    endtask

    task automatic feed();
        int gap;
        foreach (cur_q[i]) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                rx_ready = 1'b0;
                @(posedge clk); #1;
            end
            rx_data  = cur_q[i];
            rx_ready = 1'b1;
            #1;
            check("rx_clear_load", rx_clear, 1);
            check("core_rx_ready_load", core_rx_ready, 0);
            if (cur_q[i] == 8'h21) begin
                check("core_rst_before_term", core_rst, 1);
                check("load_done_before_term", load_done, 0);
            end
            @(posedge clk); #1;
        end
        rx_ready = 1'b0;
    endtask

    task automatic final_check(input string name);
        model_run();
        check({name, ":load_done"}, load_done, m_done);
        check({name, ":core_rst"}, core_rst, !m_done);
        check({name, ":err_overflow"}, err_overflow, m_ovf);
        check({name, ":err_unbalanced"}, err_unbalanced, m_unb);
        @(posedge clk); #1;
        check({name, ":prog_len"}, prog_len, m_len);
        check({name, ":wr_en_idle"}, prog_wr_en, 0);
        check({name, ":write_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check($sformatf("%s:write%0d", name, i), obs_q[i], exp_q[i]);
    endtask

    task automatic mid_load_restart(input bit use_rst);
        do_reset();
        load_str("++");
        feed();
        // A byte offered alongside the restart is consumed but must not be stored.
        rx_data = 8'h2B; rx_ready = 1'b1;
        if (use_rst) rst = 1'b1; else reload = 1'b1;
        #1;
        check("restart_rx_clear", rx_clear, 1);
        @(posedge clk); #1;
        rst = 1'b0; reload = 1'b0; rx_ready = 1'b0;
        check("restart_prog_len", prog_len, 0);
        check("restart_core_rst", core_rst, 1);
        check("restart_wr_en", prog_wr_en, 0);
        obs_q.delete();
        load_str("-!");
        feed();
        final_check(use_rst ? "rst_mid" : "reload_mid");
    endtask

    vec_t         vecs[9];
    byte unsigned alpha[11] = '{8'h3E, 8'h3C, 8'h2B, 8'h2D, 8'h2E, 8'h2C, 8'h5B, 8'h5D,
                                8'h61, 8'h20, 8'h0A};

    initial begin
        vecs[0] = '{"+[-]!",    4, 1, 0, 0};
        vecs[1] = '{"a+ \n.!",  2, 1, 0, 0};
        vecs[2] = '{"][!",      2, 0, 0, 1};
        vecs[3] = '{"+++++!",   4, 0, 1, 0};
        vecs[4] = '{"++++!",    4, 1, 0, 0};
        vecs[5] = '{"!",        0, 1, 0, 0};
        vecs[6] = '{"[[[[!",    4, 0, 0, 1};
        vecs[7] = '{"[][]!",    4, 1, 0, 0};
        vecs[8] = '{"[]x[]+!",  4, 0, 1, 0};

        rst = 1'b1; reload = 1'b0; rx_ready = 1'b0; core_rx_clear = 1'b0; rx_data = 8'h00;
        @(posedge clk); #1;
        check("reset_core_rst", core_rst, 1);
        check("reset_wr_en", prog_wr_en, 0);
        check("reset_wr_addr", prog_wr_addr, 0);
        check("reset_wr_data", prog_wr_data, 0);
        check("reset_prog_len", prog_len, 0);
        check("reset_load_done", load_done, 0);
        check("reset_err_overflow", err_overflow, 0);
        check("reset_err_unbalanced", err_unbalanced, 0);

        foreach (vecs[v]) begin
            do_reset();
            load_str(vecs[v].prog);
            feed();
            check($sformatf("vec%0d:load_done", v), load_done, vecs[v].done);
            check($sformatf("vec%0d:err_overflow", v), err_overflow, vecs[v].ovf);
            check($sformatf("vec%0d:err_unbalanced", v), err_unbalanced, vecs[v].unb);
            final_check($sformatf("vec%0d", v));
            check($sformatf("vec%0d:len_table", v), prog_len, vecs[v].len);
        end

        // Pass-through in DONE, then rst forcing core_rst combinationally.
        do_reset();
        load_str("+!");
        feed();
        final_check("passthru");
        rx_data = 8'h41; rx_ready = 1'b1; core_rx_clear = 1'b0;
        #1;
        check("pt_core_rx_ready", core_rx_ready, 1);
        check("pt_core_rx_data", core_rx_data, 8'h41);
        check("pt_rx_clear_hold", rx_clear, 0);
        core_rx_clear = 1'b1;
        #1;
        check("pt_rx_clear_ack", rx_clear, 1);
        @(posedge clk); #1;
        rx_ready = 1'b0; core_rx_clear = 1'b0;
        check("pt_still_done", load_done, 1);
        check("pt_no_write", prog_wr_en, 0);
        rst = 1'b1;
        #1;
        check("rst_forces_core_rst", core_rst, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_clears_done", load_done, 0);

        // Unbalanced ']' flags immediately; ERROR drains input and holds flags.
        do_reset();
        load_str("]");
        feed();
        check("unb_at_close", err_unbalanced, 1);
        load_str("[!");
        feed();
        load_str("][!");
        final_check("unbal");
        rx_data = 8'h41; rx_ready = 1'b1;
        #1;
        check("err_rx_clear", rx_clear, 1);
        check("err_core_rx_ready", core_rx_ready, 0);
        @(posedge clk); #1;
        rx_ready = 1'b0;
        check("err_flag_holds", err_unbalanced, 1);
        check("err_core_rst", core_rst, 1);
        check("err_load_done", load_done, 0);
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
        check("reload_clears_unb", err_unbalanced, 0);
        obs_q.delete();
        load_str("+!");
        feed();
        final_check("after_err_reload");

        mid_load_restart(1'b0);
        mid_load_restart(1'b1);

        for (int r = 0; r < 40; r++) begin
            int n;
            do_reset();
            cur_q.delete();
            n = $urandom_range(0, 7);
            for (int k = 0; k < n; k++) cur_q.push_back(alpha[$urandom_range(0, 10)]);
            cur_q.push_back(8'h21);
            feed();
            final_check($sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
